neander_control_unit: RTL



---
 rtl/neander_ctrl_pkg.sv | 103 ++++++++++
 rtl/neander_ctrl_decode.sv | 51 +++++
 rtl/neander_control_unit.sv | 125 ++++++++++++
 3 files changed

// File: rtl/neander_ctrl_pkg.sv
// Shared types for the Neander control unit: states, opcodes, ALU ops
// and the per-state strobe bundle.
package neander_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH_ADDR,
    S_FETCH_READ,
    S_FETCH_IR,
    S_DECODE,
    S_OPR_ADDR,
    S_OPR_READ,
    S_JMP_READ,
    S_EA_ADDR,
    S_STA_DATA,
    S_STA_WRITE,
    S_EXEC_READ,
    S_EXEC_ALU,
    S_JMP_LOAD,
    S_HALT
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_STA = 4'h1;
  localparam logic [3:0] OP_LDA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_AND = 4'h5;
  localparam logic [3:0] OP_NOT = 4'h6;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JN  = 4'h9;
  localparam logic [3:0] OP_JZ  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ALU_PASS_B = 3'd0;
  localparam logic [2:0] ALU_ADD    = 3'd1;
  localparam logic [2:0] ALU_OR     = 3'd2;
  localparam logic [2:0] ALU_AND    = 3'd3;
  localparam logic [2:0] ALU_NOT    = 3'd4;

  typedef struct packed {
    logic       ld_pc;
    logic       inc_pc;
    logic       ld_rem;
    logic       sel_rem;
    logic       ld_rdm;
    logic       sel_rdm;
    logic       ld_ri;
    logic       ld_ac;
    logic       ld_nz;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic [2:0] alu_op;
  } ctrl_t;

  function automatic ctrl_t ctrl_of(
    input state_t     s,
    input logic       taken,
    input logic [2:0] aop
  );
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH_ADDR,
      S_OPR_ADDR:   c.ld_rem = 1'b1;
      S_FETCH_READ,
      S_OPR_READ: begin
        c.mem_rd = 1'b1;
        c.ld_rdm = 1'b1;
        c.inc_pc = 1'b1;
      end
      S_JMP_READ,
      S_EXEC_READ: begin
        c.mem_rd = 1'b1;
        c.ld_rdm = 1'b1;
      end
      S_FETCH_IR:   c.ld_ri = 1'b1;
      S_EA_ADDR: begin
        c.ld_rem  = 1'b1;
        c.sel_rem = 1'b1;
      end
      S_STA_DATA: begin
        c.ld_rdm  = 1'b1;
        c.sel_rdm = 1'b1;
      end
      S_STA_WRITE:  c.mem_wr = 1'b1;
      S_EXEC_ALU: begin
        c.ld_ac  = 1'b1;
        c.ld_nz  = 1'b1;
        c.alu_op = aop;
      end
      S_JMP_LOAD: begin
        c.ld_pc  = taken;
        c.inc_pc = ~taken;
      end
      S_HALT:       c.halted = 1'b1;
      default:      ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/neander_ctrl_decode.sv
// Combinational opcode-to-class decode for the Neander control unit.
module neander_ctrl_decode
  import neander_ctrl_pkg::*;
(
  input  logic [3:0] op_i,
  output logic       is_mem,
  output logic       is_sta,
  output logic       is_jump,
  output logic       is_not,
  output logic       is_hlt,
  output logic [2:0] alu_op
);

  always_comb begin
    is_mem  = 1'b0;
    is_sta  = 1'b0;
    is_jump = 1'b0;
    is_not  = 1'b0;
    is_hlt  = 1'b0;
    alu_op  = ALU_PASS_B;
    unique case (1'b1)
      (op_i == OP_STA): begin
        is_mem = 1'b1;
        is_sta = 1'b1;
      end
      (op_i == OP_LDA): is_mem = 1'b1;
      (op_i == OP_ADD): begin
        is_mem = 1'b1;
        alu_op = ALU_ADD;
      end
      (op_i == OP_OR): begin
        is_mem = 1'b1;
        alu_op = ALU_OR;
      end
      (op_i == OP_AND): begin
        is_mem = 1'b1;
        alu_op = ALU_AND;
      end
      (op_i == OP_NOT): begin
        is_not = 1'b1;
        alu_op = ALU_NOT;
      end
      (op_i == OP_JMP),
      (op_i == OP_JN),
      (op_i == OP_JZ):  is_jump = 1'b1;
      (op_i == OP_HLT): is_hlt = 1'b1;
      default:          ;
    endcase
  end

endmodule

// File: rtl/neander_control_unit.sv
// Neander Moore sequencer with registered strobes.
// NEANDER_MEM_WAIT_EN adds a mem_ready handshake on memory states.
module neander_control_unit
  import neander_ctrl_pkg::*;
#(
  parameter int OPCODE_WIDTH = 4,
  parameter int ALU_OP_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    run,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic                    flag_n,
  input  logic                    flag_z,
`ifdef NEANDER_MEM_WAIT_EN
  input  logic                    mem_ready,
`endif
  output logic                    ld_pc,
  output logic                    inc_pc,
  output logic                    ld_rem,
  output logic                    sel_rem,
  output logic                    ld_rdm,
  output logic                    sel_rdm,
  output logic                    ld_ri,
  output logic                    ld_ac,
  output logic                    ld_nz,
  output logic [ALU_OP_WIDTH-1:0] alu_op,
  output logic                    mem_rd,
  output logic                    mem_wr,
  output logic                    halted
);

  state_t     state_q, state_d;
  ctrl_t      out_q, out_d;
  logic [3:0] op_q;
  logic [3:0] dec_op;
  logic       is_mem, is_sta, is_jump, is_not, is_hlt;
  logic [2:0] dec_alu;
  logic       taken;
  logic       mem_gate;

  // Opcode is live only in S_DECODE; later states use the latched copy.
  assign dec_op = (state_q == S_DECODE) ? 4'(opcode) : op_q;

  neander_ctrl_decode u_dec (
    .op_i    (dec_op),
    .is_mem  (is_mem),
    .is_sta  (is_sta),
    .is_jump (is_jump),
    .is_not  (is_not),
    .is_hlt  (is_hlt),
    .alu_op  (dec_alu)
  );

  assign taken = (op_q == OP_JMP)
               | ((op_q == OP_JN) & flag_n)
               | ((op_q == OP_JZ) & flag_z);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (run) state_d = S_FETCH_ADDR;
      S_FETCH_ADDR: state_d = S_FETCH_READ;
      S_FETCH_READ: state_d = S_FETCH_IR;
      S_FETCH_IR:   state_d = S_DECODE;
      S_DECODE: begin
        if (is_hlt)                state_d = S_HALT;
        else if (is_not)           state_d = S_EXEC_ALU;
        else if (is_mem | is_jump) state_d = S_OPR_ADDR;
        else                       state_d = S_FETCH_ADDR;
      end
      S_OPR_ADDR:
        state_d = is_jump ? S_JMP_READ : S_OPR_READ;
      S_OPR_READ:   state_d = S_EA_ADDR;
      S_EA_ADDR:
        state_d = is_sta ? S_STA_DATA : S_EXEC_READ;
      S_STA_DATA:   state_d = S_STA_WRITE;
      S_EXEC_READ:  state_d = S_EXEC_ALU;
      S_JMP_READ:   state_d = S_JMP_LOAD;
      S_STA_WRITE,
      S_EXEC_ALU,
      S_JMP_LOAD:   state_d = S_FETCH_ADDR;
      S_HALT:       state_d = S_HALT;
      default:      state_d = S_IDLE;
    endcase
`ifdef NEANDER_MEM_WAIT_EN
    if ((out_q.mem_rd | out_q.mem_wr) & ~mem_ready)
      state_d = state_q;
`endif
    out_d = ctrl_of(state_d, taken, dec_alu);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      op_q    <= OP_NOP;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      if (state_q == S_DECODE) op_q <= 4'(opcode);
    end
  end

`ifdef NEANDER_MEM_WAIT_EN
  assign mem_gate = ~(out_q.mem_rd | out_q.mem_wr) | mem_ready;
`else
  assign mem_gate = 1'b1;
`endif

  assign ld_pc   = out_q.ld_pc;
  assign inc_pc  = out_q.inc_pc & mem_gate;
  assign ld_rem  = out_q.ld_rem;
  assign sel_rem = out_q.sel_rem;
  assign ld_rdm  = out_q.ld_rdm & mem_gate;
  assign sel_rdm = out_q.sel_rdm;
  assign ld_ri   = out_q.ld_ri;
  assign ld_ac   = out_q.ld_ac;
  assign ld_nz   = out_q.ld_nz;
  assign alu_op  = ALU_OP_WIDTH'(out_q.alu_op);
  assign mem_rd  = out_q.mem_rd;
  assign mem_wr  = out_q.mem_wr;
  assign halted  = out_q.halted;

endmodule
